// File: rtl/dec_ix_queue_pkg.sv
// Shared core constants for the decode -> issue boundary.
// Decode, the issue queue and issue all size their bundles from here.
package dec_ix_queue_pkg;
  localparam int IX_BUNDLE_W = 248;
  localparam int DQ_DEPTH    = 4;

  typedef logic [IX_BUNDLE_W-1:0] ix_bundle_t;
endpackage

// File: rtl/dec_ix_queue.sv
// Decode-to-issue bundle queue: first-word fall-through FIFO with flush.
// Every output is a function of registered state, plus rst gating dec_ix_ready.
module dec_ix_queue
  import dec_ix_queue_pkg::*;
#(
  parameter int DEPTH = DQ_DEPTH,
  parameter int WIDTH = IX_BUNDLE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         dec_ix_bundle,
  input  logic                     dec_ix_valid,
  output logic                     dec_ix_ready,
  input  logic                     ix_flush,
  output logic [WIDTH-1:0]         dq_ix_bundle,
  output logic                     dq_ix_valid,
  input  logic                     ix_dq_ready,
  output logic [$clog2(DEPTH):0]   dq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Ready comes only from occupancy, so a pop into a full queue cannot free a slot early.
  assign dec_ix_ready = (count_q != FULL_CNT) && !rst;
  assign dq_ix_valid  = (count_q != '0);
  assign dq_ix_bundle = mem_q[rd_ptr_q];
  assign dq_count     = count_q;

  assign push = dec_ix_valid && dec_ix_ready && !ix_flush;
  assign pop  = dq_ix_valid && ix_dq_ready && !ix_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (ix_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately left out of reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_ix_bundle;
  end

endmodule

// File: tb/tb_dec_ix_queue.sv
// Directed bench for dec_ix_queue with a queue-based reference model and per-cycle compare.
module tb_dec_ix_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 248;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   dec_ix_bundle;
  logic               dec_ix_valid;
  logic               dec_ix_ready;
  logic               ix_flush;
  logic [WIDTH-1:0]   dq_ix_bundle;
  logic               dq_ix_valid;
  logic               ix_dq_ready;
  logic [2:0]         dq_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] mq [$];

  dec_ix_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_ix_bundle(dec_ix_bundle),
    .dec_ix_valid (dec_ix_valid),
    .dec_ix_ready (dec_ix_ready),
    .ix_flush     (ix_flush),
    .dq_ix_bundle (dq_ix_bundle),
    .dq_ix_valid  (dq_ix_valid),
    .ix_dq_ready  (ix_dq_ready),
    .dq_count     (dq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue, updated from the inputs and its own occupancy.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else if (ix_flush) begin
      mq.delete();
    end else begin
      automatic bit do_push = dec_ix_valid && (mq.size() != DEPTH);
      automatic bit do_pop  = ix_dq_ready && (mq.size() != 0);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(dec_ix_bundle);
    end
  end

  // Compare process: outputs are registered, so sample them on the falling edge.
  always @(negedge clk) begin
    chk("cyc_count", WIDTH'(dq_count), WIDTH'(mq.size()));
    chk("cyc_valid", WIDTH'(dq_ix_valid), WIDTH'(mq.size() != 0));
    chk("cyc_ready", WIDTH'(dec_ix_ready), WIDTH'((mq.size() != DEPTH) && !rst));
    if (mq.size() != 0) chk("cyc_head", dq_ix_bundle, mq[0]);
  end

  task automatic cycle(input bit v, input logic [WIDTH-1:0] b, input bit r, input bit f);
    dec_ix_valid  = v;
    dec_ix_bundle = b;
    ix_dq_ready   = r;
    ix_flush      = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    dec_ix_valid = 1'b0;
    dec_ix_bundle = '0;
    ix_dq_ready = 1'b0;
    ix_flush = 1'b0;
    #1;
    chk("rst_ready", WIDTH'(dec_ix_ready), '0);
    chk("rst_valid", WIDTH'(dq_ix_valid), '0);
    chk("rst_count", WIDTH'(dq_count), '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", WIDTH'(dec_ix_ready), WIDTH'(1));

    // Fill four, try a fifth, then drain in order.
    for (int i = 1; i <= 4; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
    chk("fill_count", WIDTH'(dq_count), WIDTH'(4));
    chk("fill_ready", WIDTH'(dec_ix_ready), '0);
    cycle(1'b1, WIDTH'(5), 1'b0, 1'b0);
    chk("fifth_ignored", WIDTH'(dq_count), WIDTH'(4));
    for (int i = 1; i <= 4; i++) begin
      chk("drain_head", dq_ix_bundle, WIDTH'(i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    chk("drain_empty", WIDTH'(dq_ix_valid), '0);

    // Full with simultaneous pop and offer: the offer must not be taken.
    for (int i = 0; i < 4; i++) cycle(1'b1, WIDTH'(8'h11 + i), 1'b0, 1'b0);
    cycle(1'b1, WIDTH'(8'hAA), 1'b1, 1'b0);
    chk("fullpop_count", WIDTH'(dq_count), WIDTH'(3));
    for (int i = 0; i < 3; i++) begin
      chk("fullpop_head", dq_ix_bundle, WIDTH'(8'h12 + i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    chk("fullpop_no_aa", WIDTH'(dq_ix_valid), '0);

    // Flush overrides push and pop in the same cycle.
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(8'h21 + i), 1'b0, 1'b0);
    cycle(1'b1, WIDTH'(8'hBB), 1'b1, 1'b1);
    chk("flush_count", WIDTH'(dq_count), '0);
    chk("flush_valid", WIDTH'(dq_ix_valid), '0);
    chk("flush_ready", WIDTH'(dec_ix_ready), WIDTH'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("flush_no_bb", WIDTH'(dq_ix_valid), '0);

    // Streaming: one in, one out per cycle after the first push.
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, WIDTH'(16'h300 + k), 1'b1, 1'b0);
      chk("stream_count", WIDTH'(dq_count), WIDTH'(1));
      chk("stream_head", dq_ix_bundle, WIDTH'(16'h300 + k));
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drained", WIDTH'(dq_count), '0);

    // Pointer wrap with random stalls on both sides.
    begin
      int pushed = 0;
      int budget = 0;
      while ((pushed < 10 || mq.size() != 0) && budget < 300) begin
        automatic bit v = (pushed < 10) && ($urandom_range(0, 3) != 0);
        automatic bit r = ($urandom_range(0, 2) != 0);
        if (v && mq.size() != DEPTH) pushed++;
        cycle(v, WIDTH'(16'h400 + (v ? pushed - 1 : 0)), r, 1'b0);
        chk("wrap_bound", WIDTH'(dq_count <= 3'd4), WIDTH'(1));
        budget++;
      end
      chk("wrap_done", WIDTH'(budget < 300), WIDTH'(1));
    end

    // Asynchronous reset with two entries queued.
    cycle(1'b1, WIDTH'(16'h501), 1'b0, 1'b0);
    cycle(1'b1, WIDTH'(16'h502), 1'b0, 1'b0);
    dec_ix_valid = 1'b0;
    chk("pre_rst_count", WIDTH'(dq_count), WIDTH'(2));
    #2 rst = 1'b1;
    #1;
    chk("async_valid", WIDTH'(dq_ix_valid), '0);
    chk("async_ready", WIDTH'(dec_ix_ready), '0);
    chk("async_count", WIDTH'(dq_count), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel_ready", WIDTH'(dec_ix_ready), WIDTH'(1));
    chk("rel_count", WIDTH'(dq_count), '0);
    cycle(1'b1, WIDTH'(16'h55), 1'b0, 1'b0);
    chk("rel_new_head", dq_ix_bundle, WIDTH'(16'h55));
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("rel_empty", WIDTH'(dq_ix_valid), '0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
